// File: rtl/rifl_temporal_pkg.sv
// Shared types for the temporal channel-bonding blocks.
package rifl_temporal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } phase_state_t;

endpackage

// File: rtl/toggle_edge_det.sv
// Registers a slow-domain toggle twice and flags the cycle in which it changed.
module toggle_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic toggle_i,
  output logic edge_o
);

  logic t_q;
  logic t_qq;

  // NOTE: non-blocking assignments let t_qq see t_q's old value, giving a true two-stage pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q  <= 1'b0;
      t_qq <= 1'b0;
    end else begin
      t_q  <= toggle_i;
      t_qq <= t_q;
    end
  end

  assign edge_o = t_q ^ t_qq;

endmodule

// File: rtl/slow2fast_phase_ctrl.sv
// Fast-clock phase counter aligned to a slow-domain toggle, with hunt/check/lock
// tracking and a saturating phase-error counter.
module slow2fast_phase_ctrl
  import rifl_temporal_pkg::*;
#(
  parameter int unsigned RATIO      = 2,
  parameter int unsigned EDGE_PHASE = 1,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned ERR_W      = 16,
  localparam int unsigned CNT_W     = $clog2(RATIO)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             slow_toggle,
  input  logic             err_cnt_clr,
  output logic [CNT_W-1:0] clk_cnt,
  output logic             locked,
  output logic             phase_err_pulse,
  output logic [ERR_W-1:0] phase_err_cnt
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(ERR_THRESH + 1);
  localparam logic [CNT_W-1:0] CHK_PHASE = CNT_W'(EDGE_PHASE);
  localparam logic [CNT_W-1:0] RELOAD    = CNT_W'((EDGE_PHASE + 1) % RATIO);

  if (RATIO < 2) begin : g_ratio_chk
    $error("slow2fast_phase_ctrl: RATIO must be >= 2");
  end
  if (EDGE_PHASE >= RATIO) begin : g_phase_chk
    $error("slow2fast_phase_ctrl: EDGE_PHASE must be < RATIO");
  end

  phase_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              locked_q, locked_d;
  logic              pulse_q, pulse_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              tgl_edge;
  logic              mismatch;

  toggle_edge_det u_edge_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .toggle_i (slow_toggle),
    .edge_o   (tgl_edge)
  );

  assign cnt_inc  = (cnt_q == CNT_W'(RATIO - 1)) ? '0 : cnt_q + CNT_W'(1);
  // An edge off the check point and a silent check point are both one error.
  assign mismatch = tgl_edge ^ (cnt_q == CHK_PHASE);

  always_comb begin
    // NOTE: every next-state signal gets a default up front so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_inc;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    err_d    = err_q;
    good_d   = good_q;
    bad_d    = bad_q;

    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        locked_d = 1'b0;
        state_d  = HUNT;
      end
      HUNT: begin
        if (tgl_edge) begin
          cnt_d   = RELOAD;
          good_d  = GOOD_W'(1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch && tgl_edge) begin
          cnt_d  = RELOAD;
          good_d = GOOD_W'(1);
        end else if (mismatch) begin
          good_d  = '0;
          state_d = HUNT;
        end else if (tgl_edge) begin
          good_d = good_q + GOOD_W'(1);
          if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (mismatch) begin
          pulse_d = 1'b1;
          err_d   = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
          if (bad_q == BAD_W'(ERR_THRESH - 1)) begin
            bad_d    = '0;
            locked_d = 1'b0;
            state_d  = HUNT;
          end else begin
            bad_d = bad_q + BAD_W'(1);
          end
        end else if (tgl_edge) begin
          bad_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
      pulse_d  = 1'b0;
      err_d    = err_q;
      good_d   = '0;
      bad_d    = '0;
    end

    if (err_cnt_clr) begin
      err_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

  assign clk_cnt         = cnt_q;
  assign locked          = locked_q;
  assign phase_err_pulse = pulse_q;
  assign phase_err_cnt   = err_q;

endmodule
